// File: rtl/piped_accum_tree.sv
`default_nettype none
// ============================================================================
// Module   : piped_accum_tree
// Purpose  : Pipelined binary adder tree with selectable signed/unsigned
//            arithmetic, plus a windowed accumulator with overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module piped_accum_tree #(
  parameter int N_args      = 2,
  parameter int arg_width   = 8,
  parameter int signed_mode = 0,
  parameter int reg_every   = 1,
  parameter int acc_ext     = 8,
  parameter int cnt_width   = 16,
  localparam int H          = $clog2(N_args),
  localparam int OUT_WIDTH  = arg_width + H,
  localparam int ACC_WIDTH  = OUT_WIDTH + acc_ext,
  localparam int L          = (H == 0) ? 1 : (H + reg_every - 1) / reg_every
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_args*arg_width-1:0] args_in,
  input  logic                        we,
  input  logic [cnt_width-1:0]        dump_len,
  input  logic                        clr,
  output logic [OUT_WIDTH-1:0]        sum_out,
  output logic                        sum_valid,
  output logic [ACC_WIDTH-1:0]        acc_out,
  output logic                        acc_valid,
  output logic                        acc_ovf
);

  localparam bit SGN = (signed_mode != 0);

  // Level i holds ceil(N_args / 2^i) operands, each arg_width + i bits wide.
  for (genvar i = 0; i <= H; i++) begin : g_lvl
    localparam int NC = (N_args + (1 << i) - 1) >> i;
    localparam int W  = arg_width + i;
    logic [W-1:0] w_op [NC];

    if (i == 0) begin : g_leaf
      for (genvar j = 0; j < NC; j++) begin : g_lane
        assign w_op[j] = args_in[j*arg_width +: arg_width];
      end
    end else begin : g_node
      localparam int NP  = (N_args + (1 << (i - 1)) - 1) >> (i - 1);
      localparam bit REG = ((i % reg_every) == 0) || (i == H);

      for (genvar j = 0; j < NC; j++) begin : g_pair
        logic [W-2:0] w_pa;
        logic [W-1:0] w_a;
        logic [W-1:0] w_b;
        logic [W-1:0] w_s;

        assign w_pa = g_lvl[i-1].w_op[2*j];
        assign w_a  = {SGN & w_pa[W-2], w_pa};

        if (2*j + 1 < NP) begin : g_two
          logic [W-2:0] w_pb;
          assign w_pb = g_lvl[i-1].w_op[2*j+1];
          assign w_b  = {SGN & w_pb[W-2], w_pb};
        end else begin : g_odd
          assign w_b = '0;
        end

        assign w_s = w_a + w_b;

        if (REG) begin : g_reg
          logic [W-1:0] r_node;
          always_ff @(posedge clk or negedge reset) begin
            if (!reset) r_node <= '0;
            else        r_node <= w_s;
          end
          assign w_op[j] = r_node;
        end else begin : g_comb
          assign w_op[j] = w_s;
        end
      end
    end
  end

  // A single addend still gets its one register stage.
  if (H == 0) begin : g_out_flat
    logic [OUT_WIDTH-1:0] r_flat;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_flat <= '0;
      else        r_flat <= g_lvl[0].w_op[0];
    end
    assign sum_out = r_flat;
  end else begin : g_out_tree
    assign sum_out = g_lvl[H].w_op[0];
  end

  logic [L-1:0] r_vpipe;
  if (L == 1) begin : g_v1
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_vpipe <= '0;
      else        r_vpipe <= we;
    end
  end else begin : g_vn
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_vpipe <= '0;
      else        r_vpipe <= {r_vpipe[L-2:0], we};
    end
  end
  assign sum_valid = r_vpipe[L-1];

  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic [cnt_width-1:0] r_count;
  logic [cnt_width-1:0] r_len;
  logic [ACC_WIDTH-1:0] r_acc_out;
  logic                 r_acc_ovf;
  logic                 r_acc_valid;

  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH:0]   w_add;
  logic                 w_add_ovf;
  logic                 w_first;
  logic [cnt_width-1:0] w_len_eff;
  logic [cnt_width:0]   w_count_inc;
  logic                 w_last;
  logic [ACC_WIDTH-1:0] w_next_acc;
  logic                 w_next_ovf;

  always_comb begin
    if (SGN) w_ext = ACC_WIDTH'($signed(sum_out));
    else     w_ext = ACC_WIDTH'(sum_out);
  end

  always_comb begin
    w_add = {1'b0, r_acc} + {1'b0, w_ext};
    if (SGN)
      w_add_ovf = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                  (w_add[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    else
      w_add_ovf = w_add[ACC_WIDTH];
  end

  // The window length is captured by the first sample; a zero request means one.
  always_comb begin
    w_first     = (r_count == '0);
    w_len_eff   = r_len;
    if (w_first) w_len_eff = (dump_len == '0) ? cnt_width'(1) : dump_len;
    w_count_inc = {1'b0, r_count} + (cnt_width+1)'(1);
    w_last      = (w_count_inc == {1'b0, w_len_eff});
    w_next_acc  = w_first ? w_ext : w_add[ACC_WIDTH-1:0];
    w_next_ovf  = w_first ? 1'b0 : (r_ovf | w_add_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_len       <= '0;
      r_acc_out   <= '0;
      r_acc_ovf   <= 1'b0;
      r_acc_valid <= 1'b0;
    end else begin
      r_acc_valid <= 1'b0;
      if (clr) begin
        r_count <= '0;
      end else if (sum_valid) begin
        r_acc <= w_next_acc;
        r_ovf <= w_next_ovf;
        if (w_first) r_len <= w_len_eff;
        if (w_last) begin
          r_count     <= '0;
          r_acc_out   <= w_next_acc;
          r_acc_ovf   <= w_next_ovf;
          r_acc_valid <= 1'b1;
        end else begin
          r_count <= w_count_inc[cnt_width-1:0];
        end
      end
    end
  end

  assign acc_out   = r_acc_out;
  assign acc_ovf   = r_acc_ovf;
  assign acc_valid = r_acc_valid;

endmodule
`default_nettype wire

// File: tb/tb_piped_accum_tree.sv
`default_nettype none
// ============================================================================
// Module   : tb_piped_accum_tree
// Purpose  : Randomized bench for a signed and an unsigned piped_accum_tree,
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piped_accum_tree;

  // Signed instance: N=5, 4-bit lanes, reg_every=2 -> H=3, out 7, acc 8, L=2
  localparam int c_NS = 5, c_AWS = 4, c_OWS = 7, c_ACS = 8, c_LS = 2;
  // Unsigned instance: N=4, 8-bit lanes, reg_every=1 -> H=2, out 10, acc 10, L=2
  localparam int c_NU = 4, c_AWU = 8, c_OWU = 10, c_ACU = 10, c_LU = 2;
  localparam int c_CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic we = 1'b0;
  logic clr = 1'b0;
  logic [c_CW-1:0] dump_len = '0;
  logic [c_NS*c_AWS-1:0] args_s = '0;
  logic [c_NU*c_AWU-1:0] args_u = '0;

  logic [c_OWS-1:0] sum_s;
  logic             sv_s;
  logic [c_ACS-1:0] acc_s;
  logic             av_s;
  logic             ovf_s;
  logic [c_OWU-1:0] sum_u;
  logic             sv_u;
  logic [c_ACU-1:0] acc_u;
  logic             av_u;
  logic             ovf_u;

  always #5 clk = ~clk;

  piped_accum_tree #(
    .N_args(c_NS), .arg_width(c_AWS), .signed_mode(1),
    .reg_every(2), .acc_ext(1), .cnt_width(c_CW)
  ) dut_s (
    .clk(clk), .reset(reset), .args_in(args_s), .we(we),
    .dump_len(dump_len), .clr(clr),
    .sum_out(sum_s), .sum_valid(sv_s),
    .acc_out(acc_s), .acc_valid(av_s), .acc_ovf(ovf_s)
  );

  piped_accum_tree #(
    .N_args(c_NU), .arg_width(c_AWU), .signed_mode(0),
    .reg_every(1), .acc_ext(0), .cnt_width(c_CW)
  ) dut_u (
    .clk(clk), .reset(reset), .args_in(args_u), .we(we),
    .dump_len(dump_len), .clr(clr),
    .sum_out(sum_u), .sum_valid(sv_u),
    .acc_out(acc_u), .acc_valid(av_u), .acc_ovf(ovf_u)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic longint mask(input int w);
    longint one = 1;
    return (one << w) - one;
  endfunction

  function automatic bit fits(input longint v, input int w, input bit sgn);
    longint one = 1;
    if (sgn) return (v >= -(one << (w - 1))) && (v < (one << (w - 1)));
    return (v >= 0) && (v < (one << w));
  endfunction

  function automatic longint wrap(input longint v, input int w, input bit sgn);
    longint one = 1;
    longint m = one << w;
    longint r = v % m;
    if (r < 0) r += m;
    if (sgn && r >= (m >> 1)) r -= m;
    return r;
  endfunction

  function automatic longint tree_s(input logic [c_NS*c_AWS-1:0] a);
    longint t = 0;
    for (int k = 0; k < c_NS; k++) begin
      int v = int'(a[k*c_AWS +: c_AWS]);
      if (v >= 8) v -= 16;
      t += v;
    end
    return t;
  endfunction

  function automatic longint tree_u(input logic [c_NU*c_AWU-1:0] a);
    longint t = 0;
    for (int k = 0; k < c_NU; k++) t += longint'(a[k*c_AWU +: c_AWU]);
    return t;
  endfunction

  typedef struct {
    bit     v;
    longint s;
  } samp_t;

  samp_t  q_s[$];
  samp_t  q_u[$];
  samp_t  vis[2];
  longint m_acc[2];
  longint m_acc_out[2];
  int     m_cnt[2];
  int     m_len[2];
  bit     m_ovf[2];
  bit     m_aovf[2];
  bit     m_av[2];

  task automatic model_reset();
    samp_t z;
    z.v = 1'b0;
    z.s = 0;
    q_s.delete();
    q_u.delete();
    for (int k = 0; k < c_LS - 1; k++) q_s.push_back(z);
    for (int k = 0; k < c_LU - 1; k++) q_u.push_back(z);
    for (int d = 0; d < 2; d++) begin
      vis[d] = z;
      m_acc[d] = 0; m_acc_out[d] = 0;
      m_cnt[d] = 0; m_len[d] = 0;
      m_ovf[d] = 1'b0; m_aovf[d] = 1'b0; m_av[d] = 1'b0;
    end
  endtask

  task automatic acc_step(input int d, input bit sgn, input int aw, input samp_t cur);
    longint t;
    m_av[d] = 1'b0;
    if (clr) begin
      m_cnt[d] = 0;
    end else if (cur.v) begin
      if (m_cnt[d] == 0) begin
        m_len[d] = (dump_len == 0) ? 1 : int'(dump_len);
        m_acc[d] = cur.s;
        m_ovf[d] = 1'b0;
      end else begin
        t = m_acc[d] + cur.s;
        if (!fits(t, aw, sgn)) m_ovf[d] = 1'b1;
        m_acc[d] = wrap(t, aw, sgn);
      end
      m_cnt[d]++;
      if (m_cnt[d] == m_len[d]) begin
        m_cnt[d]     = 0;
        m_acc_out[d] = m_acc[d];
        m_aovf[d]    = m_ovf[d];
        m_av[d]      = 1'b1;
      end
    end
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_edge();
    samp_t n;
    acc_step(0, 1'b1, c_ACS, vis[0]);
    acc_step(1, 1'b0, c_ACU, vis[1]);
    n.v = we; n.s = tree_s(args_s);
    q_s.push_back(n);
    vis[0] = q_s.pop_front();
    n.v = we; n.s = tree_u(args_u);
    q_u.push_back(n);
    vis[1] = q_u.pop_front();
  endtask

  task automatic check_all();
    check("s_sum_out",   longint'(sum_s), vis[0].s & mask(c_OWS));
    check("s_sum_valid", longint'(sv_s),  longint'(vis[0].v));
    check("s_acc_out",   longint'(acc_s), m_acc_out[0] & mask(c_ACS));
    check("s_acc_valid", longint'(av_s),  longint'(m_av[0]));
    check("s_acc_ovf",   longint'(ovf_s), longint'(m_aovf[0]));
    check("u_sum_out",   longint'(sum_u), vis[1].s & mask(c_OWU));
    check("u_sum_valid", longint'(sv_u),  longint'(vis[1].v));
    check("u_acc_out",   longint'(acc_u), m_acc_out[1] & mask(c_ACU));
    check("u_acc_valid", longint'(av_u),  longint'(m_av[1]));
    check("u_acc_ovf",   longint'(ovf_u), longint'(m_aovf[1]));
  endtask

  logic [c_CW-1:0] dl_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15};

  initial begin
    int mode;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      we  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) dump_len = dl_tab[$urandom_range(0, 5)];
      mode = int'($urandom_range(0, 3));
      for (int k = 0; k < c_NS; k++)
        args_s[k*c_AWS +: c_AWS] = (mode == 0) ? 4'h7 :
                                   (mode == 1) ? 4'h8 : 4'($urandom);
      for (int k = 0; k < c_NU; k++)
        args_u[k*c_AWU +: c_AWU] = (mode == 0) ? 8'hFF :
                                   (mode == 1) ? 8'h00 : 8'($urandom);
      // Occasional asynchronous reset between edges, pipe usually non-empty.
      if (cyc > 20 && $urandom_range(0, 99) == 0) begin
        #1 reset = 1'b0;
        model_reset();
        #1 check_all();
        #1 reset = 1'b1;
      end
      @(posedge clk);
      model_edge();
      #1 check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piped_accum_tree.md
# piped_accum_tree

Parametrised successor to the pipelined adder for correlator and imitator DSP paths. It sums N_args lanes through a binary adder tree with selectable signed or unsigned arithmetic and a configurable register spacing. It also integrates tree results over a run-time window of dump_len samples and emits one dump per window with an overflow flag. It sits between per-channel product stages and the accumulation and readout logic.

## Interface
- N_args, 2: number of addends (1..1024).
- arg_width, 8: bits per addend.
- signed_mode, 0: 0 = unsigned, 1 = two's complement (sign-extend on every widening).
- reg_every, 1: tree levels per pipeline register (1..H). The final level is always registered.
- acc_ext, 8: extra accumulator guard bits.
- cnt_width, 16: width of dump_len.
- Derived parameters: H = ceil(log2(N_args)); out_width = arg_width + H; acc_width = out_width + acc_ext; L = ceil(H/reg_every), or 1 when H = 0.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- args_in  in  N_args*arg_width  addends; lane k occupies bits [k*arg_width +: arg_width].
- we  in  1  args_in valid this cycle.
- dump_len  in  cnt_width  samples per window; 0 behaves as 1. Latched at window start.
- clr  in  1  synchronous window restart.
- sum_out  out  out_width  tree sum.
- sum_valid  out  1  sum_out valid.
- acc_out  out  acc_width  window sum, held until the next dump.
- acc_valid  out  1  one-cycle dump strobe.
- acc_ovf  out  1  the dumped window overflowed acc_width; valid with acc_valid, held with acc_out.

## Operation
- Tree:
  - Level i pairs adjacent operands and widens by 1 bit.
  - An odd last operand passes through widened, zero- or sign-extended per signed_mode.
  - Register levels are reg_every, 2*reg_every, and so on, plus level H.
  - Registers advance every cycle. we is delayed through an L-deep valid shift register to form sum_valid.
  - Tree sums are exact; no overflow is possible.
- H = 0: sum_out = args_in registered once (L = 1).
- Accumulator (count register, cnt_width bits):
  - On sum_valid with count = 0: acc <= ext(sum_out); len_q <= max(dump_len, 1); ovf_q <= 0.
  - On sum_valid with count > 0: acc <= acc + ext(sum_out). ovf_q |= overflow of this add: carry-out when unsigned, signed overflow when signed. The result wraps modulo 2^acc_width.
  - After each accepted sample: count <= count + 1.
  - On the sample that makes count + 1 = len_q: acc_out <= the final sum; acc_ovf <= final ovf_q; acc_valid = 1 for one cycle; count <= 0.
  - dump_len changes mid-window take effect at the next window only.
- clr:
  - count <= 0; the partial window is discarded; acc_out and acc_ovf hold.
  - clr together with sum_valid: clr wins and the sample is discarded.
  - The tree pipeline is unaffected.
- Reset (any time, including mid-window or with the pipe full): every register goes to 0. Outputs are therefore sum_out = 0, sum_valid = 0, acc_out = 0, acc_valid = 0, acc_ovf = 0. In-flight samples are lost.

## Timing
- sum_valid/sum_out follow we/args_in by exactly L cycles. Throughput is 1 sample per cycle with no bubbles.
- acc_valid rises 1 cycle after the sum_valid of the window's last sample. Total latency from last we is L + 1.
- dump_len = 1: acc_valid is asserted every cycle that follows a sum_valid.
- Back-to-back windows need no idle cycle. The sample after a dump starts the new window in the same cycle the dump is strobed.
- The count wraps only via dump. len_q up to 2^cnt_width - 1 is supported.

## Test plan
- N_args=4, arg_width=8, unsigned, reg_every=1: all lanes 255, one we pulse -> sum_out=1020 (10 bits), sum_valid 2 cycles later for 1 cycle.
- N_args=5, signed, reg_every=1: all lanes -128 -> sum_out=-640 (11 bits) after L=3. Lanes {1,2,3,4,-1} -> sum_out=9.
- N_args=8, reg_every=2 (L=2): we high 16 cycles with lane values = cycle index -> 16 consecutive sum_valid, sum_out = 8*index, no gaps. Check dump_len=3 windows give sums 0+8+16=24, then 24+32+40=96, and so on, back-to-back.
- dump_len=4, sums of 10 arriving every other cycle -> acc_out=40 with a single acc_valid 1 cycle after the 4th sum_valid. Change dump_len to 2 mid-window -> the next window dumps 20.
- acc_ext=0, unsigned, N_args=2, arg_width=4: lanes 15,15 (sum 30 in 5 bits), dump_len=2 -> acc_out=28 (60 mod 32) and acc_ovf=1. The next window with sums 1,1 -> acc_out=2 and acc_ovf=0.
- clr during sample 2 of 4 -> no dump; the next 4 samples dump only their sum. Assert reset with the pipe full -> all outputs 0 immediately. First dump after release needs a full dump_len window.
